// File: rtl/reg_array_seq_if.sv
// Interface between the register-array sequencer and its surroundings.
// master : the sequencer (drives strobes, command, valid, busy, done)
// slave  : layer controller / buffer / FIFO / PE side
//   i_start, i_num_rows, i_base_addr, i_stride, i_fifo_en : pass setup
//   o_buf_rd_en, o_buf_rd_addr                            : input-buffer read
//   o_fifo_rd_en                                          : line-FIFO pop
//   o_reg_array_cmd                                       : 00 BUFIN 01 SHIFT 10 FIFOI 11 HOLD
//   o_pe_valid / i_pe_ready                               : PE handshake
//   o_busy, o_done                                        : pass status
interface reg_array_seq_if #(
    parameter int ROWS_W = 8,
    parameter int AW     = 10
);
    logic              i_start;
    logic [ROWS_W-1:0] i_num_rows;
    logic [AW-1:0]     i_base_addr;
    logic [1:0]        i_stride;
    logic              i_fifo_en;
    logic              o_buf_rd_en;
    logic [AW-1:0]     o_buf_rd_addr;
    logic              o_fifo_rd_en;
    logic [1:0]        o_reg_array_cmd;
    logic              o_pe_valid;
    logic              i_pe_ready;
    logic              o_busy;
    logic              o_done;

    modport master (
        input  i_start, i_num_rows, i_base_addr, i_stride, i_fifo_en, i_pe_ready,
        output o_buf_rd_en, o_buf_rd_addr, o_fifo_rd_en, o_reg_array_cmd,
               o_pe_valid, o_busy, o_done
    );

    modport slave (
        output i_start, i_num_rows, i_base_addr, i_stride, i_fifo_en, i_pe_ready,
        input  o_buf_rd_en, o_buf_rd_addr, o_fifo_rd_en, o_reg_array_cmd,
               o_pe_valid, o_busy, o_done
    );
endinterface

// File: rtl/reg_array_seq.sv
// Register-array sequencer. For each row of a pass: fetch the row (buffer
// read or FIFO pop), load it into the array, then present KSIZE kernel-column
// positions to the PEs with a one-element shift between positions.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : reg_array_seq_if master (setup, read strobes, array command,
//                PE valid/ready handshake, busy/done status)
// All outputs are decoded from registered state; address and indices are
// registers.
module reg_array_seq #(
    parameter int KSIZE  = 3,
    parameter int ROWS_W = 8,
    parameter int AW     = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_array_seq_if.master bus
);
    localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;

    localparam logic [1:0] CMD_BUFIN = 2'b00;
    localparam logic [1:0] CMD_SHIFT = 2'b01;
    localparam logic [1:0] CMD_FIFOI = 2'b10;
    localparam logic [1:0] CMD_HOLD  = 2'b11;

    localparam logic [KW-1:0]     K_LAST = KW'(KSIZE - 1);
    localparam logic [ROWS_W-1:0] R_FIFO = ROWS_W'(KSIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_EMIT, S_SHIFT, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ROWS_W-1:0] r_idx;
    logic [ROWS_W-1:0] num_rows;
    logic [KW-1:0]     k_idx;
    logic [AW-1:0]     addr;
    logic [1:0]        stride_eff;
    logic              fifo_en;

    logic from_fifo;
    logic last_pos;
    logic last_row;

    // The first KSIZE rows always come from the buffer: the line FIFO only
    // holds rows that earlier passes through the array have already seen.
    assign from_fifo = fifo_en && (r_idx >= R_FIFO);
    assign last_pos  = (k_idx == K_LAST);
    assign last_row  = ((r_idx + ROWS_W'(1)) == num_rows);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            k_idx      <= '0;
            addr       <= '0;
            num_rows   <= '0;
            stride_eff <= 2'd1;
            fifo_en    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_idx      <= '0;
                        k_idx      <= '0;
                        addr       <= bus.i_base_addr;
                        num_rows   <= bus.i_num_rows;
                        stride_eff <= (bus.i_stride == 2'd0) ? 2'd1 : bus.i_stride;
                        fifo_en    <= bus.i_fifo_en;
                    end
                end
                S_EMIT: begin
                    // Address advances every row (FIFO rows included) so it
                    // always equals base + r*stride, wrapping modulo 2^AW.
                    if (bus.i_pe_ready && last_pos && !last_row) begin
                        r_idx <= r_idx + ROWS_W'(1);
                        k_idx <= '0;
                        addr  <= addr + AW'(stride_eff);
                    end
                end
                S_SHIFT: k_idx <= k_idx + KW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt           = state;
        bus.o_reg_array_cmd = CMD_HOLD;
        bus.o_buf_rd_en     = 1'b0;
        bus.o_fifo_rd_en    = 1'b0;
        bus.o_buf_rd_addr   = addr;
        bus.o_pe_valid      = 1'b0;
        bus.o_busy          = (state != S_IDLE);
        bus.o_done          = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.i_start)
                    state_nxt = (bus.i_num_rows == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                bus.o_buf_rd_en  = !from_fifo;
                bus.o_fifo_rd_en = from_fifo;
                state_nxt        = S_LOAD;
            end
            S_LOAD: begin
                bus.o_reg_array_cmd = from_fifo ? CMD_FIFOI : CMD_BUFIN;
                state_nxt           = S_EMIT;
            end
            S_EMIT: begin
                bus.o_pe_valid = 1'b1;
                if (bus.i_pe_ready) begin
                    if (!last_pos)     state_nxt = S_SHIFT;
                    else if (last_row) state_nxt = S_DONE;
                    else               state_nxt = S_FETCH;
                end
            end
            S_SHIFT: begin
                bus.o_reg_array_cmd = CMD_SHIFT;
                state_nxt           = S_EMIT;
            end
            S_DONE: begin
                bus.o_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_reg_array_seq.sv
// Self-checking bench for reg_array_seq. A per-pass reference trace is built
// from the row/position rules (row loop, KSIZE positions, stalls from a
// ready pattern) and compared cycle by cycle against the DUT outputs.
module tb_reg_array_seq;
    localparam int KSIZE  = 3;
    localparam int ROWS_W = 8;
    localparam int AW     = 10;

    localparam logic [1:0] HOLD = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_array_seq_if #(.ROWS_W(ROWS_W), .AW(AW)) bus ();

    reg_array_seq #(.KSIZE(KSIZE), .ROWS_W(ROWS_W), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    bit          rdy [0:4095];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic busy, input logic done, input logic valid,
                                         input logic frd, input logic brd, input logic [1:0] cmd,
                                         input logic [AW-1:0] a);
        return {15'd0, busy, done, valid, frd, brd, cmd, a};
    endfunction

    function automatic logic [31:0] observe();
        return pack(bus.o_busy, bus.o_done, bus.o_pe_valid, bus.o_fifo_rd_en, bus.o_buf_rd_en,
                    bus.o_reg_array_cmd, bus.o_buf_rd_en ? bus.o_buf_rd_addr : '0);
    endfunction

    // mode 0: always ready, 1: random ready, 2: ready low for 4 cycles at 2nd EMIT
    task automatic run_pass(input int n, input int base, input int stride, input bit fen,
                            input int mode, input string tag);
        int c = 0;
        int stalls = 0;
        int seff;
        int done_idx = -1;
        for (int i = 0; i < 4096; i++) begin
            if (mode == 1 && i < 2000) rdy[i] = ($urandom_range(0, 9) < 7);
            else                       rdy[i] = 1'b1;
        end
        if (mode == 2) for (int i = 4; i < 8; i++) rdy[i] = 1'b0;

        seff = (stride == 0) ? 1 : stride;
        exp_q.delete();
        for (int r = 0; r < n; r++) begin
            logic [AW-1:0] a;
            bit fifo;
            a    = AW'(base + r * seff);
            fifo = fen && (r >= KSIZE);
            exp_q.push_back(pack(1, 0, 0, fifo, !fifo, HOLD, fifo ? '0 : a)); c++;
            exp_q.push_back(pack(1, 0, 0, 0, 0, fifo ? 2'b10 : 2'b00, '0));   c++;
            for (int j = 0; j < KSIZE; j++) begin
                while (!rdy[c]) begin
                    exp_q.push_back(pack(1, 0, 1, 0, 0, HOLD, '0)); c++; stalls++;
                end
                exp_q.push_back(pack(1, 0, 1, 0, 0, HOLD, '0)); c++;
                if (j < KSIZE - 1) begin
                    exp_q.push_back(pack(1, 0, 0, 0, 0, 2'b01, '0)); c++;
                end
            end
        end
        exp_q.push_back(pack(1, 1, 0, 0, 0, HOLD, '0));
        exp_q.push_back(pack(0, 0, 0, 0, 0, HOLD, '0));

        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_num_rows  = ROWS_W'(n);
        bus.i_base_addr = AW'(base);
        bus.i_stride    = 2'(stride);
        bus.i_fifo_en   = fen;
        @(posedge clk); #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            bus.i_pe_ready = rdy[i];
            if (i == 0) begin
                // second start while busy must be ignored
                bus.i_num_rows  = ROWS_W'(n + 3);
                bus.i_base_addr = ~AW'(base);
            end else begin
                bus.i_start = 1'b0;
            end
            check($sformatf("%s cyc%0d", tag, i), observe(), exp_q[i]);
            if (bus.o_done && done_idx < 0) done_idx = i;
            @(posedge clk); #1;
        end
        bus.i_start    = 1'b0;
        bus.i_pe_ready = 1'b1;
        check($sformatf("%s done_cycle", tag), 32'(done_idx), 32'((2 * KSIZE + 1) * n + stalls));
    endtask

    initial begin
        bus.i_start     = 1'b0;
        bus.i_num_rows  = '0;
        bus.i_base_addr = '0;
        bus.i_stride    = '0;
        bus.i_fifo_en   = 1'b0;
        bus.i_pe_ready  = 1'b1;

        // reset held for 3 cycles
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", observe(), pack(0, 0, 0, 0, 0, HOLD, '0));
        check("rst_addr", 32'(bus.o_buf_rd_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_out", observe(), pack(0, 0, 0, 0, 0, HOLD, '0));

        run_pass(2, 'h010, 1, 1'b0, 0, "p2");
        run_pass(5, 'h3FE, 2, 1'b1, 0, "wrap");
        run_pass(2, 'h010, 1, 1'b0, 2, "stall");
        run_pass(0, 'h055, 1, 1'b0, 0, "zero");
        run_pass(4, 'h200, 0, 1'b0, 0, "str0");

        // reset during LOAD of row 1
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_num_rows  = 8'd3;
        bus.i_base_addr = 10'h100;
        bus.i_stride    = 2'd1;
        bus.i_fifo_en   = 1'b0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("ld1_cmd", 32'(bus.o_reg_array_cmd), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", observe(), pack(0, 0, 0, 0, 0, HOLD, '0));
        check("async_addr", 32'(bus.o_buf_rd_addr), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_nodone", observe(), pack(0, 0, 0, 0, 0, HOLD, '0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst", observe(), pack(0, 0, 0, 0, 0, HOLD, '0));
        run_pass(3, 'h100, 1, 1'b0, 0, "fresh");

        for (int t = 0; t < 10; t++) begin
            run_pass($urandom_range(0, 12), $urandom_range(0, 1023), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1, $sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
